// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the hex UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // 'A' - 10 == 8'h37, so letters and digits share one adder
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - byte-level 8N1 transmitter with a tvalid/tready byte input
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tdata_i,
  input  logic       tvalid_i,
  output logic       tready_o,
  output logic       tx_o
);

  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign tx_o    = tx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // The stop bit's final cycle also accepts a byte so characters run back to back
  always_comb begin
    state_d  = state_q;
    baud_d   = '0;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tready_o = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: begin
        tready_o = 1'b1;
        if (tvalid_i) begin
          shreg_d = tdata_i;
          state_d = START;
        end
      end
      START: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          tready_o = 1'b1;
          if (tvalid_i) begin
            shreg_d = tdata_i;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shreg_d[0];
  end

endmodule

// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - prints a captured value as uppercase ASCII hex (plus optional CR LF) over UART
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 8,
  parameter bit CRLF_EN    = 1'b1
) (
  input  logic                  clk100_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int ND  = DATA_WIDTH / 4;
  localparam int L   = ND + (CRLF_EN ? 2 : 0);
  localparam int IW  = $clog2(L + 1);
  localparam logic [IW-1:0] IDX_END = IW'(L);

  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] src;
  logic [3:0]            nib;
  logic [7:0]            chr;
  logic                  accept, msg_done, core_tvalid, core_tready;

  assign ready_o     = ~busy_q;
  assign busy_o      = busy_q;
  assign accept      = valid_i && ready_o;
  assign msg_done    = busy_q && core_tready && (idx_q == IDX_END);
  assign core_tvalid = accept || (busy_q && (idx_q != IDX_END));

  // While idle, character 0 comes straight from data_i so the start bit leaves one cycle after accept
  always_comb begin
    src = busy_q ? data_q : data_i;
    nib = '0;
    for (int k = 0; k < ND; k++) begin
      if (idx_q == IW'(ND - 1 - k)) nib = src[4*k +: 4];
    end
    if (idx_q < IW'(ND))       chr = nibble_to_ascii(nib);
    else if (idx_q == IW'(ND)) chr = ASCII_CR;
    else                       chr = ASCII_LF;
  end

  always_comb begin
    busy_d = busy_q;
    data_d = data_q;
    idx_d  = idx_q;
    if (accept) begin
      busy_d = 1'b1;
      data_d = data_i;
      idx_d  = IW'(1);
    end else if (msg_done) begin
      busy_d = 1'b0;
      idx_d  = '0;
    end else if (busy_q && core_tready) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end

  uart_tx_core #(.DIV(DIV)) u_core (
    .clk_i    (clk100_i),
    .rst_i    (rst_i),
    .tdata_i  (chr),
    .tvalid_i (core_tvalid),
    .tready_o (core_tready),
    .tx_o     (tx_o)
  );

endmodule
